dtmr_redundancy_ctrl: RTL

Redundancy controller for the DTMR datapath. It decides when the three motor-control replicas run in simplex or triple-voted mode, using the operating mode and the received error rate. It sequences warm-up and per-replica resynchronisation after a voter fault, and quarantines a replica that faults repeatedly. It sits beside the voter, drives the replica enables and the voter select, and consumes the voter's per-replica fault flags.

---
 rtl/dtmr_pkg.sv | 39 +++
 rtl/dtmr_hyst_counter.sv | 34 +++
 rtl/dtmr_redundancy_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dtmr_pkg.sv
// ============================================================================
// Package  : dtmr_pkg
// Brief    : Mode/state encodings and replica-selection helpers for the DTMR
//            redundancy controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dtmr_pkg;

    localparam logic [1:0] c_MODE_AUTO   = 2'd0;
    localparam logic [1:0] c_MODE_HYBRID = 2'd1;
    localparam logic [1:0] c_MODE_MANUAL = 2'd2;
    localparam logic [1:0] c_MODE_SLEEP  = 2'd3;

    localparam logic [2:0] c_ST_SLEEP   = 3'd0;
    localparam logic [2:0] c_ST_SIMPLEX = 3'd1;
    localparam logic [2:0] c_ST_WARMUP  = 3'd2;
    localparam logic [2:0] c_ST_TRIPLE  = 3'd3;
    localparam logic [2:0] c_ST_RESYNC  = 3'd4;

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        onehot3 = 3'b001 << idx;
    endfunction

    // Lowest replica that is neither quarantined nor excluded; 0 if none remain.
    function automatic logic [1:0] lowest_healthy(input logic [2:0] quar,
                                                  input logic [2:0] excl);
        logic [2:0] avail;
        avail = ~(quar | excl);
        if (avail[0])      lowest_healthy = 2'd0;
        else if (avail[1]) lowest_healthy = 2'd1;
        else if (avail[2]) lowest_healthy = 2'd2;
        else               lowest_healthy = 2'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dtmr_hyst_counter.sv
// ============================================================================
// Module   : dtmr_hyst_counter
// Brief    : Saturating consecutive-condition counter with a clear input.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dtmr_hyst_counter #(
    parameter int HYST = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_cond,
    input  logic i_clr,
    output logic o_done
);

    localparam logic [7:0] c_HYST = 8'(HYST);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr || !i_cond) begin
            r_cnt <= 8'd0;
        end else if (r_cnt != c_HYST) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_done = (r_cnt == c_HYST);

endmodule

`default_nettype wire

// File: rtl/dtmr_redundancy_ctrl.sv
// ============================================================================
// Module   : dtmr_redundancy_ctrl
// Brief    : Chooses simplex/triple-voted operation of the three DTMR replicas,
//            sequences warm-up and resync, and quarantines repeat offenders.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dtmr_redundancy_ctrl
    import dtmr_pkg::*;
#(
    parameter int ERR_HI  = 8,
    parameter int ERR_LO  = 3,
    parameter int HYST    = 16,
    parameter int WARMUP  = 4,
    parameter int RESYNC  = 8,
    parameter int STRIKES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic [3:0] err_rate,
    input  logic       vote_valid,
    input  logic [2:0] fault,
    output logic [2:0] mod_en,
    output logic       tmr_on,
    output logic [1:0] primary,
    output logic [2:0] resync,
    output logic [2:0] quarantined,
    output logic       uncorr,
    output logic       fail,
    output logic [2:0] state_o
);

    localparam logic [4:0] c_ERR_HI      = 5'(ERR_HI);
    localparam logic [4:0] c_ERR_LO      = 5'(ERR_LO);
    localparam logic [7:0] c_WARMUP_LAST = 8'(WARMUP - 1);
    localparam logic [7:0] c_RESYNC_LAST = 8'(RESYNC - 1);
    localparam logic [2:0] c_STRIKES     = 3'(STRIKES);

    logic [2:0]      r_state;
    logic [7:0]      r_tcnt;
    logic [1:0]      r_rs_idx;
    logic [2:0][2:0] r_strike;

    logic [2:0]      w_state_nxt;
    logic [7:0]      w_tcnt_nxt;
    logic [1:0]      w_rs_idx_nxt;
    logic [2:0][2:0] w_strike_nxt;
    logic [2:0]      w_quar_nxt;
    logic            w_uncorr_nxt;
    logic            w_state_change;

    logic [2:0]      w_mod_en_nxt;
    logic            w_tmr_nxt;
    logic [1:0]      w_primary_nxt;
    logic [2:0]      w_resync_nxt;

    logic            w_entry_cond;
    logic            w_exit_cond;
    logic            w_entry_done;
    logic            w_exit_done;
    logic            w_fault_onehot;
    logic            w_fault_multi;

    assign w_fault_onehot = (fault == 3'b001) || (fault == 3'b010) || (fault == 3'b100);
    assign w_fault_multi  = (fault[0] & fault[1]) | (fault[0] & fault[2]) | (fault[1] & fault[2]);

    assign w_entry_cond = (r_state == c_ST_SIMPLEX) &&
                          (((mode == c_MODE_AUTO)   && ({1'b0, err_rate} >= c_ERR_HI)) ||
                           ((mode == c_MODE_HYBRID) && ({1'b0, err_rate} >= c_ERR_LO)));
    assign w_exit_cond  = (r_state == c_ST_TRIPLE) && (mode == c_MODE_AUTO) &&
                          ({1'b0, err_rate} < c_ERR_LO);

    assign w_state_change = (w_state_nxt != r_state);

    dtmr_hyst_counter #(.HYST(HYST)) u_entry_hyst (
        .clk    (clk),
        .rst    (rst),
        .i_cond (w_entry_cond),
        .i_clr  (w_state_change),
        .o_done (w_entry_done)
    );

    dtmr_hyst_counter #(.HYST(HYST)) u_exit_hyst (
        .clk    (clk),
        .rst    (rst),
        .i_cond (w_exit_cond),
        .i_clr  (w_state_change),
        .o_done (w_exit_done)
    );

    // Sleep outranks fault handling, which outranks threshold transitions.
    always_comb begin
        w_state_nxt  = r_state;
        w_rs_idx_nxt = r_rs_idx;
        w_strike_nxt = r_strike;
        w_quar_nxt   = quarantined;
        w_uncorr_nxt = 1'b0;
        if (mode == c_MODE_SLEEP) begin
            w_state_nxt = c_ST_SLEEP;
        end else begin
            case (r_state)
                c_ST_SLEEP: w_state_nxt = c_ST_SIMPLEX;
                c_ST_SIMPLEX: begin
                    if ((quarantined == 3'b000) &&
                        ((mode == c_MODE_MANUAL) || w_entry_done)) begin
                        w_state_nxt = c_ST_WARMUP;
                    end
                end
                c_ST_WARMUP: begin
                    if (r_tcnt == c_WARMUP_LAST) w_state_nxt = c_ST_TRIPLE;
                end
                c_ST_TRIPLE: begin
                    if (vote_valid && w_fault_onehot) begin
                        w_state_nxt = c_ST_RESYNC;
                        for (int i = 0; i < 3; i++) begin
                            if (fault[i]) begin
                                w_strike_nxt[i] = (r_strike[i] == c_STRIKES) ?
                                                  r_strike[i] : r_strike[i] + 3'd1;
                                w_rs_idx_nxt    = 2'(i);
                                if (w_strike_nxt[i] == c_STRIKES) begin
                                    w_quar_nxt[i] = 1'b1;
                                    w_state_nxt   = c_ST_SIMPLEX;
                                end
                            end
                        end
                    end else if (vote_valid && w_fault_multi) begin
                        w_uncorr_nxt = 1'b1;
                        w_state_nxt  = c_ST_WARMUP;
                    end else if (w_exit_done) begin
                        w_state_nxt = c_ST_SIMPLEX;
                    end
                end
                c_ST_RESYNC: begin
                    if (r_tcnt == c_RESYNC_LAST) w_state_nxt = c_ST_TRIPLE;
                end
                default: w_state_nxt = c_ST_SIMPLEX;
            endcase
        end
    end

    always_comb begin
        w_tcnt_nxt = 8'd0;
        if (!w_state_change && ((r_state == c_ST_WARMUP) || (r_state == c_ST_RESYNC))) begin
            w_tcnt_nxt = r_tcnt + 8'd1;
        end
    end

    always_comb begin
        w_mod_en_nxt  = 3'b000;
        w_tmr_nxt     = 1'b0;
        w_resync_nxt  = 3'b000;
        w_primary_nxt = lowest_healthy(w_quar_nxt, 3'b000);
        case (w_state_nxt)
            c_ST_SIMPLEX: w_mod_en_nxt = (&w_quar_nxt) ? 3'b000 : onehot3(w_primary_nxt);
            c_ST_WARMUP:  w_mod_en_nxt = ~w_quar_nxt;
            c_ST_TRIPLE: begin
                w_mod_en_nxt = 3'b111;
                w_tmr_nxt    = 1'b1;
            end
            c_ST_RESYNC: begin
                w_mod_en_nxt  = ~w_quar_nxt;
                w_resync_nxt  = onehot3(w_rs_idx_nxt);
                w_primary_nxt = lowest_healthy(w_quar_nxt, onehot3(w_rs_idx_nxt));
            end
            default: w_mod_en_nxt = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_SIMPLEX;
            r_tcnt      <= 8'd0;
            r_rs_idx    <= 2'd0;
            r_strike    <= '0;
            mod_en      <= 3'b001;
            tmr_on      <= 1'b0;
            primary     <= 2'd0;
            resync      <= 3'b000;
            quarantined <= 3'b000;
            uncorr      <= 1'b0;
            fail        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tcnt      <= w_tcnt_nxt;
            r_rs_idx    <= w_rs_idx_nxt;
            r_strike    <= w_strike_nxt;
            mod_en      <= w_mod_en_nxt;
            tmr_on      <= w_tmr_nxt;
            primary     <= w_primary_nxt;
            resync      <= w_resync_nxt;
            quarantined <= w_quar_nxt;
            uncorr      <= w_uncorr_nxt;
            fail        <= &w_quar_nxt;
        end
    end

    assign state_o = r_state;

endmodule

`default_nettype wire
